piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//   Parallel-in serial-out stage that converts WIDTH-bit words into a 1-bit serial stream.
//   Sits directly upstream of the siso shift-register stage; its so output drives that stage's si.
//   Uses a valid/ready load handshake and supports gapless back-to-back words.
//   Frames are LSB-first by default, which preserves bit order through the downstream right-shifting register.
// PARAMETERS
//   WIDTH      4   data word width in bits, >= 2
//   MSB_FIRST  0   0: bit 0 goes out first; 1: bit WIDTH-1 goes out first
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous reset, active-low (0 = reset)
//   din         in   WIDTH  parallel word; sampled only on an accept edge
//   load_valid  in   1      producer has a word on din
//   load_ready  out  1      serializer can take a word this cycle
//   so          out  1      serial data bit (registered)
//   so_valid    out  1      so carries a frame bit this cycle (registered)
//   busy        out  1      a frame is in progress (state != IDLE)
//   done        out  1      one-cycle pulse coincident with the final bit of a frame
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, shift reg=0, bit count=0.
//     so=0, so_valid=0, busy=0, done=0 immediately. load_ready=1 once rst=1.
//   - Accept: on a rising clk edge with load_valid && load_ready. din is captured into the shift reg.
//   - Latency: the first bit appears on so in the cycle after the accept edge.
//     Data bit k appears k+1 cycles after accept.
//   - FSM states: IDLE, SHIFT (plus PARITY when the parity feature is enabled).
//     IDLE  -> SHIFT on accept.
//     SHIFT -> emits one bit per cycle, count 0..WIDTH-1.
//     At count==WIDTH-1: go to SHIFT again (count=0) if a new word is accepted; otherwise go to IDLE.
//   - load_ready: combinational, = (state==IDLE) || (final bit cycle of the current frame).
//     Back-to-back words therefore stream with no idle gap.
//   - load_valid while load_ready=0 is ignored. The producer must hold din and load_valid until accepted.
//   - din changes between accepts have no effect on the frame in flight.
//   - In IDLE: so=0, so_valid=0. In SHIFT: so_valid=1.
//   - done=1 only during the final bit of a frame (the data bit, or the parity bit when enabled).
//   - Bit counter is $clog2(WIDTH+1) bits wide and wraps to 0 on each frame start. It never exceeds the frame length.
//   - Reset mid-frame aborts the frame. Partially sent bits are not resent, and no done pulse is generated.
// CONFIGURATION
//   PISO_PARITY_EN defined:
//     - After the last data bit, the FSM enters PARITY for one cycle.
//     - so = even parity (XOR of all WIDTH captured bits), so_valid=1, done=1 in that cycle.
//     - Frame length is WIDTH+1. load_ready is asserted during the PARITY cycle, not during the last data bit.
//   PISO_PARITY_EN undefined:
//     - PARITY state is not built. Frame length is WIDTH. done and load_ready apply to data bit WIDTH-1.
// TESTING  (WIDTH=4, MSB_FIRST=0 unless noted)
//   1. Release reset; load 4'b1011 once.
//      -> so = 1,1,0,1 on cycles 1-4 after accept; so_valid high exactly 4 cycles.
//      -> done high on cycle 4 only; back in IDLE with so=0 on cycle 5.
//   2. Hold load_valid for 4'b0110 then 4'b1001, presenting the second word during the final bit.
//      -> so = 0,1,1,0,1,0,0,1 with no gap; so_valid high 8 consecutive cycles; two done pulses.
//   3. Raise load_valid with 4'b1111 in the second bit cycle of a frame.
//      -> load_ready=0; the word is not taken until the final bit cycle; current frame unaffected.
//   4. Pull rst low in the middle of bit 2 (between clk edges).
//      -> so, so_valid, busy drop to 0 immediately; no done; next accept starts a fresh frame at bit 0.
//   5. MSB_FIRST=1; load 4'b1000.
//      -> so = 1,0,0,0 on cycles 1-4.
//   6. PISO_PARITY_EN defined; load 4'b1011.
//      -> so = 1,1,0,1,1; done and load_ready on the 5th cycle only.
//      -> load 4'b0011 -> parity bit 0.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a valid/ready load handshake.
// Emits WIDTH-bit words one bit per cycle, LSB-first unless MSB_FIRST=1,
// and streams back-to-back words with no idle gap.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// after each frame (frame length WIDTH+1).
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             so_q, so_d;
    logic             so_valid_q, so_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    // Bit of a word that goes out first in the configured order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its leading bit removed, next bit moved into the leading position.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready in IDLE and during the final bit of a frame, enabling gapless streaming.
`ifdef PISO_PARITY_EN
    assign load_ready = (state_q == ST_IDLE) || (state_q == ST_PARITY);
`else
    assign load_ready = (state_q == ST_IDLE) ||
                        ((state_q == ST_SHIFT) && (cnt_q == LAST_CNT));
`endif

    assign accept = load_valid && load_ready;

    // Next-state and next-output logic; sreg holds the bits not yet on so.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        so_d       = 1'b0;
        so_valid_d = 1'b0;
        start      = 1'b0;
`ifdef PISO_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != LAST_CNT) begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    so_d       = first_bit(sreg_q);
                    sreg_d     = shift_out(sreg_q);
                    so_valid_d = 1'b1;
                end else begin
`ifdef PISO_PARITY_EN
                    state_d    = ST_PARITY;
                    so_d       = par_q;
                    so_valid_d = 1'b1;
                    cnt_d      = '0;
                    sreg_d     = '0;
`else
                    if (accept) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        sreg_d  = '0;
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (accept) begin
                    start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    sreg_d  = '0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sreg_d  = '0;
            end
        endcase

        // Frame start: first bit goes straight to so, the rest wait in sreg.
        if (start) begin
            state_d    = ST_SHIFT;
            cnt_d      = '0;
            so_d       = first_bit(din);
            sreg_d     = shift_out(din);
            so_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
            par_d      = ^din;
`endif
        end

        busy_d = (state_d != ST_IDLE);
`ifdef PISO_PARITY_EN
        done_d = (state_d == ST_PARITY);
`else
        done_d = (state_d == ST_SHIFT) && (cnt_d == LAST_CNT);
`endif
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef PISO_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign so       = so_q;
    assign so_valid = so_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
